// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: reads a byte-wide instruction memory one byte per cycle, assembles
// little-endian 32-bit words, hands them off on valid/ready and halts after a run of NOPs.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                NOP_LIMIT = 3,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [7:0]        imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);

    localparam int NOP_W  = $clog2(NOP_LIMIT + 1);
    localparam int LANE_W = $clog2(BYTES_PER_WORD);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    // Handshake contract: a word transfers on any edge where instr_valid & instr_ready;
    // instr/instr_pc/instr_valid stay frozen while instr_valid is high and ready is low,
    // and instr_ready is ignored while instr_valid is low.

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] halt_addr;
    logic [LANE_W-1:0] byte_cnt;
    logic [NOP_W-1:0]  nop_cnt;
    logic [NOP_W-1:0]  nop_next;
    logic              handshake;

    assign handshake = instr_valid & instr_ready;

    always_comb begin
        nop_next = '0;
        if (instr == NOP_WORD) begin
            nop_next = nop_cnt + 1'b1;
        end
    end

    // HALT freezes the address that was on the bus when the last word was consumed.
    always_comb begin
        imem_addr = halt_addr;
        case (state)
            FETCH:   imem_addr = pc + ADDR_W'(byte_cnt);
            HOLD:    imem_addr = pc + ADDR_W'(BYTES_PER_WORD - 1);
            default: imem_addr = halt_addr;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            halt_addr   <= RESET_PC;
            byte_cnt    <= '0;
            nop_cnt     <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (state != HALT) begin
            if (redirect_valid) begin
                // Redirect wins over any coincident byte capture or handshake.
                pc          <= redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
                byte_cnt    <= '0;
                instr_valid <= 1'b0;
                nop_cnt     <= '0;
                state       <= FETCH;
            end else if (state == FETCH) begin
                instr[{byte_cnt, 3'b000} +: 8] <= imem_rdata;
                if (byte_cnt == LAST_LANE) begin
                    byte_cnt    <= '0;
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    state       <= HOLD;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (handshake) begin
                pc          <= pc + ADDR_W'(BYTES_PER_WORD);
                instr_valid <= 1'b0;
                nop_cnt     <= nop_next;
                if (nop_next == NOP_W'(NOP_LIMIT)) begin
                    state     <= HALT;
                    halted    <= 1'b1;
                    halt_addr <= imem_addr;
                end else begin
                    state <= FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios followed by random
// ready/redirect traffic, checked against a word-level model of the fetch stream.
module tb_instruction_fetch_unit;

    localparam int         NOP_LIMIT = 3;
    localparam logic [7:0] RESET_PC  = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halted;

    logic [7:0]  mem [256];
    logic [39:0] exp_q [$];

    int          n_checks = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [7:0]  exp_pc = 8'h00;
    int          wait_n = 0;
    bit          seen = 1'b0;
    int          nop_run = 0;
    bit          m_halted = 1'b0;
    logic [7:0]  halt_addr_exp = 8'h00;

    instruction_fetch_unit #(
        .ADDR_W    (8),
        .NOP_LIMIT (NOP_LIMIT),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .halted         (halted)
    );

    // Clock and combinational memory
    always #5 clk = ~clk;
    assign imem_rdata = mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [7:0] b1, b2, b3;
        b1 = a + 8'd1;
        b2 = a + 8'd2;
        b3 = a + 8'd3;
        return {mem[b3], mem[b2], mem[b1], mem[a]};
    endfunction

    task automatic push_expected(input logic [7:0] a);
        exp_q.push_back({a, word_at(a)});
    endtask

    // Driver tasks
    task automatic step(input logic rdy, input logic rv, input logic [7:0] rpc);
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        exp_pc   = RESET_PC;
        wait_n   = 0;
        seen     = 1'b0;
        nop_run  = 0;
        m_halted = 1'b0;
        push_expected(RESET_PC);
        mon_en   = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 12 && !instr_valid; i++) step(1'b0, 1'b0, 8'h00);
        n_checks++;
        if (!instr_valid) begin
            n_fail++;
            $display("FAIL %s_timeout: instr_valid=0, expected 1 within 12 cycles", name);
        end
    endtask

    task automatic async_reset_check(input string name);
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk({name, "_valid"},  {31'd0, instr_valid}, 32'd0);
        chk({name, "_halted"}, {31'd0, halted},      32'd0);
        chk({name, "_addr"},   {24'd0, imem_addr},   {24'd0, RESET_PC});
        chk({name, "_instr"},  instr,                32'd0);
    endtask

    // Monitor / scoreboard: model works in whole words and next-word addresses
    always @(negedge clk) begin
        logic [39:0] w;
        if (mon_en) begin
            if (m_halted) begin
                chk("halt_valid", {31'd0, instr_valid}, 32'd0);
                chk("halt_flag",  {31'd0, halted},      32'd1);
                chk("halt_addr",  {24'd0, imem_addr},   {24'd0, halt_addr_exp});
            end else begin
                chk("halted_low", {31'd0, halted}, 32'd0);
                if (!instr_valid) begin
                    chk("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc + 8'(wait_n)});
                    wait_n++;
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: instr_valid=1 with no expected word");
                end else begin
                    if (!seen) chk("latency", 32'(wait_n), 32'd4);
                    seen = 1'b1;
                    chk("instr",     instr,               exp_q[0][31:0]);
                    chk("instr_pc",  {24'd0, instr_pc},   {24'd0, exp_q[0][39:32]});
                    chk("hold_addr", {24'd0, imem_addr},  {24'd0, exp_pc + 8'd3});
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    exp_pc  = redirect_pc & 8'hFC;
                    push_expected(exp_pc);
                    wait_n  = 0;
                    seen    = 1'b0;
                    nop_run = 0;
                end else if (instr_valid && instr_ready && exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    if (w[31:0] == 32'd0) nop_run++;
                    else nop_run = 0;
                    if (nop_run == NOP_LIMIT) begin
                        m_halted      = 1'b1;
                        halt_addr_exp = exp_pc + 8'd3;
                    end else begin
                        exp_pc = exp_pc + 8'd4;
                        push_expected(exp_pc);
                    end
                    wait_n = 0;
                    seen   = 1'b0;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        {mem[3], mem[2], mem[1], mem[0]}             = 32'h200a000a;
        {mem[7], mem[6], mem[5], mem[4]}             = 32'h016a5820;
        {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14]} = 32'h8d4d0000;
        {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]} = 32'h00000000;

        #3;
        chk("reset_addr",  {24'd0, imem_addr},   32'd0);
        chk("reset_valid", {31'd0, instr_valid}, 32'd0);
        do_reset();

        // Little-endian assembly and back-to-back words
        wait_valid("t1");
        chk("t1_instr", instr, 32'h200a000a);
        chk("t1_pc", {24'd0, instr_pc}, 32'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("t2_valid_drop", {31'd0, instr_valid}, 32'd0);
        wait_valid("t2");
        chk("t2_instr", instr, 32'h016a5820);
        chk("t2_pc", {24'd0, instr_pc}, 32'h04);

        // Backpressure
        repeat (6) step(1'b0, 1'b0, 8'h00);
        chk("t3_instr", instr, 32'h016a5820);
        chk("t3_pc", {24'd0, instr_pc}, 32'h04);
        chk("t3_addr", {24'd0, imem_addr}, 32'h07);
        step(1'b1, 1'b0, 8'h00);
        chk("t3_next_addr", {24'd0, imem_addr}, 32'h08);

        // Redirect while byte 2 is due
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h15);
        chk("t4_valid", {31'd0, instr_valid}, 32'd0);
        chk("t4_addr", {24'd0, imem_addr}, 32'h14);
        wait_valid("t4");
        chk("t4_instr", instr, 32'h8d4d0000);
        chk("t4_pc", {24'd0, instr_pc}, 32'h14);

        // NOP run across the wrap, then halt
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        step(1'b1, 1'b1, 8'hFC);
        wait_valid("t5a");
        chk("t5_pc0", {24'd0, instr_pc}, 32'hFC);
        step(1'b1, 1'b0, 8'h00);
        wait_valid("t5b");
        chk("t5_pc1", {24'd0, instr_pc}, 32'h00);
        step(1'b1, 1'b0, 8'h00);
        wait_valid("t5c");
        chk("t5_pc2", {24'd0, instr_pc}, 32'h04);
        chk("t5_not_yet", {31'd0, halted}, 32'd0);
        step(1'b1, 1'b0, 8'h00);
        chk("t5_halted", {31'd0, halted}, 32'd1);
        chk("t5_valid", {31'd0, instr_valid}, 32'd0);
        repeat (3) step(1'b1, 1'b1, 8'h40);
        chk("t5_redir_ignored", {31'd0, halted}, 32'd1);
        chk("t5_addr_frozen", {24'd0, imem_addr}, 32'h07);

        // Asynchronous reset mid-fetch
        do_reset();
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        async_reset_check("t6");
        do_reset();
        wait_valid("t6");
        chk("t6_pc", {24'd0, instr_pc}, 32'h00);

        // Random traffic, some zero words so halting occurs
        for (int r = 0; r < 6; r++) begin
            mon_en = 1'b0;
            for (int w = 0; w < 64; w++) begin
                for (int b = 0; b < 4; b++) begin
                    mem[w*4 + b] = (r[0] && $urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                end
                if ($urandom_range(0, 3) == 0) begin
                    for (int b = 0; b < 4; b++) mem[w*4 + b] = 8'h00;
                end
            end
            do_reset();
            repeat (250) begin
                step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0),
                     8'($urandom_range(0, 255)));
            end
            async_reset_check("rand_reset");
        end

        do_reset();
        repeat (2) step(1'b0, 1'b0, 8'h00);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
